// File: rtl/tone_sequencer_if.sv
// Configuration and tone-generator bus for tone_sequencer.
// The master modport belongs to the controller; the slave modport belongs to the sequencer.
interface tone_sequencer_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [5:0]    wr_note;
    logic [7:0]    wr_dur;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW:0]   seq_len;
    logic [3:0]    vol_in;
    logic          set_out;
    logic [31:0]   clks_per_period;
    logic [3:0]    vol_out;
    logic [5:0]    note_out;
    logic [AW-1:0] step_idx;
    logic          busy;
    logic          done;

    modport master (
        output wr_en, wr_addr, wr_note, wr_dur, start, stop, loop_en, seq_len, vol_in,
        input  set_out, clks_per_period, vol_out, note_out, step_idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_note, wr_dur, start, stop, loop_en, seq_len, vol_in,
        output set_out, clks_per_period, vol_out, note_out, step_idx, busy, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Melody sequencer: walks a note memory and programs the PWM tone generator step by step.
// Define GAP_TENUTO_EN to add a silent articulation set GAP_TICKS before the end of each long note.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | note memory read of step_idx
// ISSUE | period/volume computed, set strobe registered on exit
// HOLD  | note sounding, duration timer running
module tone_sequencer #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int TICK_DIV  = 1000000,
    parameter int GAP_TICKS = 1
) (
    input  logic            clk,
    input  logic            reset,
    tone_sequencer_if.slave bus
);
    localparam int            TW        = $clog2(TICK_DIV + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]    GAP_CNT   = 8'(GAP_TICKS);
    localparam logic [31:0]   PERIOD_C5 = 32'd191112;
    localparam logic [5:0]    NOTE_C5   = 6'd28;
    localparam logic [5:0]    NOTE_MAX  = 6'd48;
    localparam logic [5:0]    NOTE_REST = 6'd63;
`ifdef GAP_TENUTO_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   step_idx_q, step_idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            set_out_q, set_out_d;
    logic [31:0]     period_q, period_d;
    logic [3:0]      vol_q, vol_d;
    logic [5:0]      note_q, note_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [7:0]      dur_cnt_q, dur_cnt_d;

    logic [13:0]     mem_q [DEPTH];
    logic [13:0]     rd_data_q;

    logic [5:0]      rd_note;
    logic [7:0]      rd_dur;
    logic            rd_rest;
    logic [31:0]     rd_period;
    logic            hold_expired;
    logic            last_step;
    logic            gap_hit;

    // C1 periods are for octave 0; each octave up halves the period.
    function automatic logic [31:0] note_period(input logic [5:0] code);
        logic [5:0]  n_eff;
        logic [2:0]  n_mod;
        logic [2:0]  oct;
        logic [31:0] base;
        n_eff = (code > NOTE_MAX) ? NOTE_MAX : code;
        n_mod = 3'(n_eff % 6'd7);
        oct   = 3'(n_eff / 6'd7);
        case (n_mod)
            3'd0:    base = 32'd3057805;
            3'd1:    base = 32'd2724194;
            3'd2:    base = 32'd2426982;
            3'd3:    base = 32'd2290765;
            3'd4:    base = 32'd2040840;
            3'd5:    base = 32'd1818182;
            3'd6:    base = 32'd1619816;
            default: base = 32'd3057805;
        endcase
        return base >> oct;
    endfunction

    // Read-first: a same-cycle write to the fetched address returns the old entry.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= {bus.wr_note, bus.wr_dur};
        end
        rd_data_q <= mem_q[step_idx_q];
    end

    always_comb begin
        rd_note      = rd_data_q[13:8];
        rd_dur       = rd_data_q[7:0];
        rd_rest      = (rd_note == NOTE_REST);
        rd_period    = note_period(rd_note);
        hold_expired = (tick_cnt_q == '0) && (dur_cnt_q == 8'd0);
        last_step    = ({1'b0, step_idx_q} + {{AW{1'b0}}, 1'b1}) >= bus.seq_len;
        gap_hit      = (dur_cnt_q == GAP_CNT) && (tick_cnt_q == '0) && (note_q != NOTE_REST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            step_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            set_out_q  <= 1'b0;
            period_q   <= PERIOD_C5;
            vol_q      <= 4'd0;
            note_q     <= NOTE_C5;
            tick_cnt_q <= '0;
            dur_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            set_out_q  <= set_out_d;
            period_q   <= period_d;
            vol_q      <= vol_d;
            note_q     <= note_d;
            tick_cnt_q <= tick_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        set_out_d  = 1'b0;
        period_d   = period_q;
        vol_d      = vol_q;
        note_d     = note_q;
        tick_cnt_d = tick_cnt_q;
        dur_cnt_d  = dur_cnt_q;

        if (state_q != S_IDLE && bus.stop) begin
            set_out_d = 1'b1;
            vol_d     = 4'd0;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.seq_len != '0) begin
                            state_d    = S_FETCH;
                            step_idx_d = '0;
                            busy_d     = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    set_out_d  = 1'b1;
                    note_d     = rd_note;
                    vol_d      = rd_rest ? 4'd0 : bus.vol_in;
                    period_d   = rd_rest ? period_q : rd_period;
                    tick_cnt_d = TICK_LAST;
                    dur_cnt_d  = (rd_dur == 8'd0) ? 8'd0 : rd_dur - 8'd1;
                    state_d    = S_HOLD;
                end
                S_HOLD: begin
                    if (hold_expired) begin
                        if (!last_step) begin
                            step_idx_d = step_idx_q + AW'(1);
                            state_d    = S_FETCH;
                        end else if (bus.loop_en) begin
                            step_idx_d = '0;
                            state_d    = S_FETCH;
                        end else begin
                            set_out_d = 1'b1;
                            vol_d     = 4'd0;
                            done_d    = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = S_IDLE;
                        end
                    end else begin
                        if (tick_cnt_q == '0) begin
                            tick_cnt_d = TICK_LAST;
                            dur_cnt_d  = dur_cnt_q - 8'd1;
                        end else begin
                            tick_cnt_d = tick_cnt_q - TW'(1);
                        end
                        // The silent set lands on the first cycle of the final GAP_TICKS window.
                        if (GAP_EN && gap_hit) begin
                            set_out_d = 1'b1;
                            vol_d     = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.set_out         = set_out_q;
    assign bus.clks_per_period = period_q;
    assign bus.vol_out         = vol_q;
    assign bus.note_out        = note_q;
    assign bus.step_idx        = step_idx_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer; a negedge monitor checks every set/done pulse against a queue.
module tb_tone_sequencer;
    localparam int AW = 4;

    typedef struct {
        int          cyc;
        logic [31:0] per;
        logic [3:0]  vol;
        logic [3:0]  step;
    } set_t;

    logic clk;
    logic reset;
    int   cyc;
    int   vectors;
    int   miscompares;
    set_t set_q[$];
    int   done_q[$];

    tone_sequencer_if #(.AW(AW)) bus();

    tone_sequencer #(
        .DEPTH(16), .AW(AW), .TICK_DIV(4), .GAP_TICKS(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void exp_set(input int c, input logic [31:0] p, input logic [3:0] v,
                                    input logic [3:0] s);
        set_t e;
        e.cyc  = c;
        e.per  = p;
        e.vol  = v;
        e.step = s;
        set_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.set_out) begin
                if (set_q.size() == 0) begin
                    chk("set_unexpected_at", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    set_t e;
                    e = set_q.pop_front();
                    chk("set_cycle", 32'(cyc), 32'(e.cyc));
                    chk("set_period", bus.clks_per_period, e.per);
                    chk("set_vol", 32'(bus.vol_out), 32'(e.vol));
                    chk("set_step", 32'(bus.step_idx), 32'(e.step));
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected_at", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
                end
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [5:0] n, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_note = n;
        bus.wr_dur  = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_pending(input string tag);
        chk(tag, 32'(set_q.size() + done_q.size()), 32'd0);
        set_q.delete();
        done_q.delete();
    endtask

    initial begin
        int c;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_note = '0;
        bus.wr_dur  = '0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        bus.seq_len = '0;
        bus.vol_in  = 4'd8;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_set_out", 32'(bus.set_out), 32'd0);
        chk("rst_period", bus.clks_per_period, 32'd191112);
        chk("rst_vol", 32'(bus.vol_out), 32'd0);
        chk("rst_note", 32'(bus.note_out), 32'd28);
        chk("rst_step", 32'(bus.step_idx), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);

        // single C5 note, dur 2 ticks of 4 clocks
        wr(4'd0, 6'd28, 8'd2);
        bus.seq_len = 5'd1;
        c = cyc;
        exp_set(c + 3, 32'd191112, 4'd8, 4'd0);
        exp_set(c + 11, 32'd191112, 4'd0, 4'd0);
        done_q.push_back(c + 11);
        pulse_start();
        wait_cyc(c + 5);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_note", 32'(bus.note_out), 32'd28);
        wait_cyc(c + 14);
        chk("t1_busy_end", 32'(bus.busy), 32'd0);
        chk_pending("t1_pending");

        // three notes, last with dur 0 treated as 1
        wr(4'd0, 6'd0, 8'd1);
        wr(4'd1, 6'd33, 8'd1);
        wr(4'd2, 6'd48, 8'd0);
        bus.seq_len = 5'd3;
        c = cyc;
        exp_set(c + 3, 32'd3057805, 4'd8, 4'd0);
        exp_set(c + 9, 32'd113636, 4'd8, 4'd1);
        exp_set(c + 15, 32'd25309, 4'd8, 4'd2);
        exp_set(c + 19, 32'd25309, 4'd0, 4'd2);
        done_q.push_back(c + 19);
        pulse_start();
        wait_cyc(c + 22);
        chk_pending("t2_pending");

        // rest keeps period, code 55 clamps to 48
        wr(4'd0, 6'd28, 8'd1);
        wr(4'd1, 6'd63, 8'd1);
        wr(4'd2, 6'd55, 8'd1);
        bus.vol_in = 4'd5;
        c = cyc;
        exp_set(c + 3, 32'd191112, 4'd5, 4'd0);
        exp_set(c + 9, 32'd191112, 4'd0, 4'd1);
        exp_set(c + 15, 32'd25309, 4'd5, 4'd2);
        exp_set(c + 19, 32'd25309, 4'd0, 4'd2);
        done_q.push_back(c + 19);
        pulse_start();
        wait_cyc(c + 11);
        chk("t3_rest_vol", 32'(bus.vol_out), 32'd0);
        chk("t3_rest_period", bus.clks_per_period, 32'd191112);
        chk("t3_rest_note", 32'(bus.note_out), 32'd63);
        wait_cyc(c + 22);
        chk_pending("t3_pending");
        bus.vol_in = 4'd8;

        // looping two steps, then stop mid-HOLD
        wr(4'd0, 6'd0, 8'd2);
        wr(4'd1, 6'd33, 8'd2);
        bus.seq_len = 5'd2;
        bus.loop_en = 1'b1;
        c = cyc;
        exp_set(c + 3, 32'd3057805, 4'd8, 4'd0);
        exp_set(c + 13, 32'd113636, 4'd8, 4'd1);
        exp_set(c + 23, 32'd3057805, 4'd8, 4'd0);
        exp_set(c + 33, 32'd113636, 4'd8, 4'd1);
        exp_set(c + 36, 32'd113636, 4'd0, 4'd1);
        pulse_start();
        wait_cyc(c + 25);
        chk("t4_step_wrap", 32'(bus.step_idx), 32'd0);
        wait_cyc(c + 35);
        chk("t4_step_pre_stop", 32'(bus.step_idx), 32'd1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        @(negedge clk);
        chk("t4_busy_after_stop", 32'(bus.busy), 32'd0);
        bus.loop_en = 1'b0;
        wait_cyc(c + 45);
        chk_pending("t4_pending");

        // empty sequence: immediate done, no set
        bus.seq_len = 5'd0;
        c = cyc;
        done_q.push_back(c + 1);
        pulse_start();
        wait_cyc(c + 6);
        chk_pending("t5_empty_pending");

        // start during playback is ignored
        wr(4'd0, 6'd0, 8'd1);
        wr(4'd1, 6'd33, 8'd1);
        bus.seq_len = 5'd2;
        c = cyc;
        exp_set(c + 3, 32'd3057805, 4'd8, 4'd0);
        exp_set(c + 9, 32'd113636, 4'd8, 4'd1);
        exp_set(c + 13, 32'd113636, 4'd0, 4'd1);
        done_q.push_back(c + 13);
        pulse_start();
        wait_cyc(c + 5);
        pulse_start();
        wait_cyc(c + 16);
        chk_pending("t5_restart_pending");

        // long note: legato by default, detached with the gap option
        wr(4'd0, 6'd0, 8'd3);
        bus.seq_len = 5'd1;
        c = cyc;
        exp_set(c + 3, 32'd3057805, 4'd8, 4'd0);
`ifdef GAP_TENUTO_EN
        exp_set(c + 11, 32'd3057805, 4'd0, 4'd0);
`endif
        exp_set(c + 15, 32'd3057805, 4'd0, 4'd0);
        done_q.push_back(c + 15);
        pulse_start();
        wait_cyc(c + 18);
        chk_pending("t6_gap_pending");

        // asynchronous reset mid-HOLD
        c = cyc;
        exp_set(c + 3, 32'd3057805, 4'd8, 4'd0);
        pulse_start();
        wait_cyc(c + 6);
        chk("t6_busy_pre_reset", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_period", bus.clks_per_period, 32'd191112);
        chk("t6_rst_vol", 32'(bus.vol_out), 32'd0);
        chk("t6_rst_note", 32'(bus.note_out), 32'd28);
        chk("t6_rst_step", 32'(bus.step_idx), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_set", 32'(bus.set_out), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_idle_busy", 32'(bus.busy), 32'd0);
        chk_pending("t6_reset_pending");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Plays a stored melody for pitch-training exercises. It drives the existing PWM tone generator's configuration interface: period, volume and a one-cycle set strobe. A small dual-port note memory holds up to DEPTH steps, each with a note code and a duration. The block walks the memory, converts each note to a PWM period, and holds it for the programmed time. It replaces button-driven note stepping whenever a melody is playing.

Parameters:
DEPTH, 16, number of sequence entries (power of 2)
AW, 4, address width, log2(DEPTH)
TICK_DIV, 1000000, clocks per duration tick (10 ms at 100 MHz)
GAP_TICKS, 1, articulation-gap length in ticks (used only with GAP_EN)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high; clears all state
wr_en  in  1  write strobe for note memory
wr_addr  in  AW  write address
wr_note  in  6  note code: 0..48 = C1..B7 (C major, 7 per octave); 63 = rest
wr_dur  in  8  step duration in ticks
start  in  1  begin playback from step 0 (pulse)
stop  in  1  abort playback (pulse)
loop_en  in  1  when 1, wrap to step 0 after the last step
seq_len  in  AW+1  number of steps, 0..DEPTH
vol_in  in  4  master volume, sampled at each ISSUE
set_out  out  1  one-cycle strobe to the tone generator
clks_per_period  out  32  PWM period in clocks
vol_out  out  4  volume to the tone generator
note_out  out  6  current note code
step_idx  out  AW  current step
busy  out  1  playback active
done  out  1  one-cycle pulse at natural end or when seq_len = 0

Behaviour:
- Reset values: set_out=0, clks_per_period=191112 (C5), vol_out=0, note_out=28, step_idx=0, busy=0, done=0. The FSM goes to IDLE. Memory contents are not cleared.
- Memory: synchronous read, read-first. Writes are accepted in any state. A write to the address being fetched in the same cycle returns the old data.
- Period: n = note mod 7, o = note / 7. clks_per_period = C1[n] >> o.
  - C1 table = 3057805, 2724194, 2426982, 2290765, 2040840, 1818182, 1619816.
  - Note codes 49..62 clamp to 48. Code 63 (rest) keeps the previous period and forces vol_out=0.
- FSM states: IDLE, FETCH, ISSUE, HOLD.
- IDLE:
  - start=1 and seq_len>0 → FETCH, with step_idx=0 and busy=1.
  - start=1 and seq_len=0 → done=1 the next cycle; stay IDLE.
- FETCH (1 cycle): memory read of step_idx.
- ISSUE (1 cycle): compute period and volume. On the exit edge, register clks_per_period, note_out and vol_out (vol_in, or 0 for a rest), and assert set_out for exactly one cycle. Then go to HOLD.
- HOLD:
  - Lasts max(dur,1)*TICK_DIV cycles; the prescaler restarts on HOLD entry.
  - On expiry with step_idx < seq_len-1: increment step_idx → FETCH.
  - On expiry at the last step with loop_en=1: step_idx=0 → FETCH.
  - On expiry at the last step with loop_en=0: silence set (set_out=1, vol_out=0, period unchanged), done=1, busy=0 → IDLE.
- Latency: start sampled at cycle k gives set_out high in cycle k+3. Set-to-set spacing is max(dur,1)*TICK_DIV + 2 clocks.
- stop=1 in any non-IDLE state: on the next edge issue a silence set, busy=0, no done pulse → IDLE. stop wins over a simultaneous start and over HOLD expiry.
- start while busy=1 is ignored.
- seq_len and loop_en are sampled at each HOLD expiry. If seq_len is reduced below step_idx+1, the current step counts as the last step.
- Reset asserted mid-playback: outputs return to reset values immediately. No silence strobe is issued; the tone generator has its own reset.

Optional Feature:
Macro GAP_TENUTO_EN.
- Defined: for any non-rest step with dur > GAP_TICKS, when the remaining HOLD count equals GAP_TICKS*TICK_DIV, issue an extra set_out with vol_out=0 and the same period. Repeated identical notes then sound detached. Step timing is unchanged.
- Undefined: notes are legato, with exactly one set per step (plus the final silence set).

Test Plan:
1. TICK_DIV=4. Load step0 = note 28, dur 2. seq_len=1, vol_in=8, start → set_out at k+3 with clks_per_period=191112 and vol_out=8. 8 cycles later: silence set with vol_out=0, plus a done pulse; busy falls.
2. Load notes 0, 33, 48 with dur 1. Play → clks_per_period sequence 3057805, 113636, 25309. set_out spacing is 6 clocks.
3. Step1 = code 63 (rest) → vol_out=0 and clks_per_period unchanged during step1. Code 55 → period 25309 (clamped).
4. loop_en=1, seq_len=2 → step_idx runs 0,1,0,1… with no done pulse. Pulse stop mid-HOLD → silence set the next cycle, busy=0, no done.
5. seq_len=0, start → done high the next cycle; no set_out. A start pulse during playback does not restart from step 0.
6. Assert reset mid-HOLD → all outputs return to reset values asynchronously. With GAP_TENUTO_EN defined, dur=3, GAP_TICKS=1 → an extra vol_out=0 set 8 clocks after the note set.
